cpu_run_controller: RTL
=======================

# cpu_run_controller

Synthesizable sequencer that loads a program image into the pipelined CPU's instruction RAM, runs the CPU until it halts or a cycle budget expires, then streams the register file out. It sits between an external host/stream port and the `CPU` top, so the load/run/dump sequence runs in hardware at any image depth, register count or run length.

## Interface
- `DATA_W`, 32, instruction and register word width
- `IMEM_DEPTH`, 64, instruction RAM words; `AW = $clog2(IMEM_DEPTH)`
- `REG_COUNT`, 32, register-file entries to dump; `RW = $clog2(REG_COUNT)`
- `CNT_W`, 20, cycle counter and limit width
- `CLK`  in  1  clock
- `RESET_N`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; begins a load/run/dump sequence
- `load_count`  in  AW+1  words to load from the stream; clamped to `IMEM_DEPTH`
- `cycle_limit`  in  CNT_W  run budget in cycles; 0 = unlimited
- `s_valid` / `s_ready` / `s_data`  in/out/in  1/1/DATA_W  program-word stream
- `imem_we` / `imem_addr` / `imem_wdata`  out  1/AW/DATA_W  instruction RAM write port
- `cpu_rst`  out  1  active-high CPU reset
- `cpu_run`  out  1  CPU clock enable
- `cpu_halt`  in  1  CPU has retired its halt instruction
- `rf_raddr` / `rf_rdata`  out/in  RW/DATA_W  register-file read port (asynchronous read)
- `m_valid` / `m_ready` / `m_data` / `m_last`  out/in/out/out  1/1/DATA_W/1  register dump stream
- `busy` / `done` / `timeout`  out  1  status
- `cycles_run`  out  CNT_W  number of cycles `cpu_run` was high in the last run

## Operation
- States: IDLE, LOAD, FILL, RUN, DUMP, DONE.
- IDLE/DONE: `cpu_rst`=1 in IDLE; `done`=1 in DONE. On `start`: latch `min(load_count, IMEM_DEPTH)` as N, clear `idx`, `cycles_run`, `timeout` and `done`, then go to LOAD (N>0) or FILL (N=0). `start` is ignored in every other state.
- LOAD: `cpu_rst`=1, `s_ready`=1. Each handshake (`s_valid & s_ready`) drives `imem_we`=1, `imem_addr`=`idx`, `imem_wdata`=`s_data`, then increments `idx`. After word N-1, go to FILL, or to RUN if N=`IMEM_DEPTH`.
- FILL: `cpu_rst`=1. Write 0 (NOP) to each address from `idx` up to `IMEM_DEPTH`-1, one per cycle, then go to RUN.
- RUN: `cpu_rst`=0, `cpu_run`=1. `cycles_run` increments every RUN cycle and saturates at all-ones without wrapping. Exit conditions:
  - If `cpu_halt`=1, go to DUMP with `timeout`=0.
  - Otherwise, if `cycle_limit`≠0 and the incremented count equals `cycle_limit`, go to DUMP with `timeout`=1.
  - If both hold in the same cycle, halt wins.
- DUMP: `cpu_rst`=0, `cpu_run`=0, so the CPU state is frozen. `rf_raddr`=`idx` (cleared on entry). `m_valid`=1, `m_data`=`rf_rdata`, `m_last`=(`idx`=`REG_COUNT`-1). Advance `idx` on handshake; after the last beat, go to DONE.
- `busy`=1 in LOAD, FILL, RUN and DUMP.

## Timing
- Reset values (applied immediately and asynchronously, including mid-sequence; the state returns to IDLE):
  - 0: `s_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `cpu_run`, `rf_raddr`, `m_valid`, `m_last`, `busy`, `done`, `timeout`, `cycles_run`
  - 1: `cpu_rst`
- `m_data` is a combinational pass-through of `rf_rdata`. It stays stable while `m_valid & !m_ready` because the address and register file are frozen.
- Handshake outputs are decoded from registered state. The `imem_*` signals are combinational with the `s_*` handshake.
- Latency:
  - `start` to first `s_ready`: 1 cycle.
  - LOAD: N cycles with `s_valid` held high.
  - FILL: `IMEM_DEPTH`-N cycles.
  - DUMP: `REG_COUNT` cycles with `m_ready` held high.
- Once in DUMP, `m_valid` never deasserts before its handshake.

## Structure
- Package `cpu_run_pkg`: state encoding localparams (IDLE=0 … DONE=5) and the NOP word constant.
- One sub-module, `sat_counter` (CNT_W-bit saturating up-counter with clear and enable), used for `cycles_run`.

## Test plan
- Load 4 words with `IMEM_DEPTH`=8 and `cycle_limit`=0 → 4 writes to addresses 0–3 with stream data, 4 zero writes to addresses 4–7, then RUN starts.
- `cpu_halt` rises on the 10th RUN cycle → `cycles_run`=10, `timeout`=0, then 32 dump beats with `m_last` only on beat 31.
- `cycle_limit`=5 and the CPU never halts → exactly 5 `cpu_run` cycles, `timeout`=1, `cycles_run`=5.
- `cpu_halt` arrives on the same cycle the limit is reached (`cycle_limit`=3, halt on cycle 3) → `timeout`=0.
- `m_ready` toggles every other cycle during DUMP → `m_data` and `rf_raddr` hold during stalls; 32 beats in order.
- `RESET_N` dropped during LOAD and during DUMP → all outputs take reset values in the same cycle; a new `start` restarts cleanly; `load_count`=100 with `IMEM_DEPTH`=64 clamps to 64 writes with no FILL.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared constants for the CPU run controller: FSM encoding, the NOP fill word
// and a small clamping helper.
package cpu_run_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] ST_FILL = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DUMP = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd5;

  // Unused instruction RAM words are padded with this encoding.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// Bundle of host stream, instruction RAM, CPU control, register dump and status
// signals between the run controller (ctrl) and its environment (host).
interface cpu_run_controller_if #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int REG_COUNT  = 32,
  parameter int CNT_W      = 20
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(REG_COUNT);

  // Streams use valid/ready: a beat transfers on a clock edge where both are
  // high; once raised, valid stays high with stable data until that beat.
  logic              start;
  logic [AW:0]       load_count;
  logic [CNT_W-1:0]  cycle_limit;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              imem_we;
  logic [AW-1:0]     imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_rst;
  logic              cpu_run;
  logic              cpu_halt;
  logic [RW-1:0]     rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycles_run;
  logic [2:0]        dbg_state;

  modport ctrl (
    input  start, load_count, cycle_limit, s_valid, s_data, cpu_halt, rf_rdata, m_ready,
    output s_ready, imem_we, imem_addr, imem_wdata, cpu_rst, cpu_run, rf_raddr,
           m_valid, m_data, m_last, busy, done, timeout, cycles_run, dbg_state
  );

  modport host (
    output start, load_count, cycle_limit, s_valid, s_data, cpu_halt, rf_rdata, m_ready,
    input  s_ready, imem_we, imem_addr, imem_wdata, cpu_rst, cpu_run, rf_raddr,
           m_valid, m_data, m_last, busy, done, timeout, cycles_run, dbg_state
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; next_o exposes the
// value the counter would take on an enabled cycle.
module sat_counter #(
  parameter int W = 20
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o
);
  logic [W-1:0] count_q, count_d;

  assign next_o  = (&count_q) ? count_q : count_q + 1'b1;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = next_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Load / fill / run / dump sequencer wrapped around the pipelined CPU: streams a
// program into instruction RAM, runs the CPU under a cycle budget, dumps registers.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int REG_COUNT  = 32,
  parameter int CNT_W      = 20
) (
  input logic              CLK,
  input logic              RESET_N,
  cpu_run_controller_if.ctrl bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(REG_COUNT);
  // idx serves both the RAM address and the register index, plus one bit so
  // the clamped load count IMEM_DEPTH is representable.
  localparam int IW = ((AW > RW) ? AW : RW) + 1;

  localparam logic [IW-1:0] DEPTH_I   = IW'(IMEM_DEPTH);
  localparam logic [IW-1:0] LAST_ADDR = IW'(IMEM_DEPTH - 1);
  localparam logic [IW-1:0] LAST_REG  = IW'(REG_COUNT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      n_q, n_d;
  logic               timeout_q, timeout_d;
  logic               cnt_clr;
  logic [CNT_W-1:0]   cnt_q, cnt_next;
  logic               s_hs, m_hs;

  assign s_hs = (state_q == ST_LOAD) & bus.s_valid;
  assign m_hs = (state_q == ST_DUMP) & bus.m_ready;

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .clr_i   (cnt_clr),
    .en_i    (state_q == ST_RUN),
    .count_o (cnt_q),
    .next_o  (cnt_next)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    n_d       = n_q;
    timeout_d = timeout_q;
    cnt_clr   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          n_d       = IW'(min_u(32'(bus.load_count), IMEM_DEPTH));
          idx_d     = '0;
          timeout_d = 1'b0;
          cnt_clr   = 1'b1;
          state_d   = (n_d == '0) ? ST_FILL : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_hs) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == n_q - 1'b1) state_d = (n_q == DEPTH_I) ? ST_RUN : ST_FILL;
        end
      end
      ST_FILL: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Halt is checked first so it wins over a budget that expires together.
        if (bus.cpu_halt) begin
          state_d   = ST_DUMP;
          idx_d     = '0;
          timeout_d = 1'b0;
        end else if ((bus.cycle_limit != '0) && (cnt_next == bus.cycle_limit)) begin
          state_d   = ST_DUMP;
          idx_d     = '0;
          timeout_d = 1'b1;
        end
      end
      ST_DUMP: begin
        if (m_hs) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_REG) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.s_ready    = (state_q == ST_LOAD);
  assign bus.imem_we    = s_hs | (state_q == ST_FILL);
  assign bus.imem_addr  = bus.imem_we ? idx_q[AW-1:0] : '0;
  assign bus.imem_wdata = s_hs ? bus.s_data : DATA_W'(NOP_WORD);
  assign bus.cpu_rst    = (state_q == ST_IDLE) | (state_q == ST_LOAD) | (state_q == ST_FILL);
  assign bus.cpu_run    = (state_q == ST_RUN);
  // Address frozen while the CPU is stopped, so m_data holds through stalls.
  assign bus.rf_raddr   = (state_q == ST_DUMP) ? idx_q[RW-1:0] : '0;
  assign bus.m_valid    = (state_q == ST_DUMP);
  assign bus.m_data     = bus.rf_rdata;
  assign bus.m_last     = (state_q == ST_DUMP) & (idx_q == LAST_REG);
  assign bus.busy       = (state_q == ST_LOAD) | (state_q == ST_FILL) |
                          (state_q == ST_RUN)  | (state_q == ST_DUMP);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.timeout    = timeout_q;
  assign bus.cycles_run = cnt_q;
  assign bus.dbg_state  = state_q;

endmodule
